// File: rtl/rename_group.sv
// Register-rename stage for one group of WIDTH lanes: speculative/committed RATs, intra-group bypass, free-list pop.
// Outputs registered (1 cycle after accept); a group is taken only when the output slot is empty or being drained.
module rename_group #(
    parameter int WIDTH     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHY_REGS  = 64,
    parameter int PHY_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*5-1:0]         in_rs1_arch,
    input  logic [WIDTH*5-1:0]         in_rs2_arch,
    input  logic [WIDTH*5-1:0]         in_rd_arch,
    input  logic [WIDTH-1:0]           in_rd_wen,
    input  logic [PHY_WIDTH:0]         fl_avail,
    input  logic [WIDTH*PHY_WIDTH-1:0] fl_phy,
    output logic [PHY_WIDTH:0]         fl_pop,
    input  logic [WIDTH-1:0]           commit_valid,
    input  logic [WIDTH*5-1:0]         commit_rd_arch,
    input  logic [WIDTH*PHY_WIDTH-1:0] commit_rd_phy,
    output logic [WIDTH-1:0]           out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*PHY_WIDTH-1:0] out_rs1_phy,
    output logic [WIDTH*PHY_WIDTH-1:0] out_rs2_phy,
    output logic [WIDTH*PHY_WIDTH-1:0] out_rd_phy_new,
    output logic [WIDTH*PHY_WIDTH-1:0] out_rd_phy_old
);
    localparam int AW = 5;
    localparam int PW = PHY_WIDTH;

    if ($clog2(PHY_REGS) != PHY_WIDTH) begin : g_cfg_err
        $error("rename_group: PHY_WIDTH must equal clog2(PHY_REGS)");
    end

    logic [PW-1:0] srat     [ARCH_REGS];
    logic [PW-1:0] crat     [ARCH_REGS];
    logic [PW-1:0] srat_nxt [ARCH_REGS];
    logic [PW-1:0] crat_nxt [ARCH_REGS];

    logic [WIDTH-1:0]    ren;
    logic [PW:0]         n_ren;
    logic                accept;
    logic [WIDTH*PW-1:0] rs1_p, rs2_p, new_p, old_p;

    assign in_ready = rst && !flush && (fl_avail >= n_ren) && ((out_valid == '0) || out_ready);
    assign accept   = in_ready && (|in_valid);
    assign fl_pop   = accept ? n_ren : '0;

    // Free-list slots are handed out in lane order to renaming lanes only.
    always_comb begin
        int k;
        ren   = '0;
        n_ren = '0;
        new_p = '0;
        k     = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ren[i] = in_valid[i] && in_rd_wen[i] && (in_rd_arch[i*AW +: AW] != '0);
            if (ren[i]) begin
                new_p[i*PW +: PW] = fl_phy[k*PW +: PW];
                n_ren = n_ren + {{PW{1'b0}}, 1'b1};
                k     = k + 1;
            end
        end
    end

    // Source/old-dest lookup: SRAT, overridden by the youngest older lane in this group writing the same register.
    always_comb begin
        rs1_p = '0;
        rs2_p = '0;
        old_p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_rs1_arch[i*AW +: AW] != '0) rs1_p[i*PW +: PW] = srat[in_rs1_arch[i*AW +: AW]];
            if (in_rs2_arch[i*AW +: AW] != '0) rs2_p[i*PW +: PW] = srat[in_rs2_arch[i*AW +: AW]];
            if (in_rd_arch[i*AW +: AW]  != '0) old_p[i*PW +: PW] = srat[in_rd_arch[i*AW +: AW]];
            for (int j = 0; j < i; j++) begin
                if (ren[j]) begin
                    if (in_rd_arch[j*AW +: AW] == in_rs1_arch[i*AW +: AW]) rs1_p[i*PW +: PW] = new_p[j*PW +: PW];
                    if (in_rd_arch[j*AW +: AW] == in_rs2_arch[i*AW +: AW]) rs2_p[i*PW +: PW] = new_p[j*PW +: PW];
                    if (in_rd_arch[j*AW +: AW] == in_rd_arch[i*AW +: AW])  old_p[i*PW +: PW] = new_p[j*PW +: PW];
                end
            end
        end
    end

    // Lane-order loops make the youngest writer win; flush restores SRAT from CRAT including this cycle's commits.
    always_comb begin
        crat_nxt = crat;
        for (int i = 0; i < WIDTH; i++) begin
            if (commit_valid[i] && (commit_rd_arch[i*AW +: AW] != '0))
                crat_nxt[commit_rd_arch[i*AW +: AW]] = commit_rd_phy[i*PW +: PW];
        end
        srat_nxt = srat;
        if (flush) begin
            srat_nxt = crat_nxt;
        end else if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ren[i]) srat_nxt[in_rd_arch[i*AW +: AW]] = new_p[i*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                srat[r] <= PW'(r);
                crat[r] <= PW'(r);
            end
            out_valid      <= '0;
            out_rs1_phy    <= '0;
            out_rs2_phy    <= '0;
            out_rd_phy_new <= '0;
            out_rd_phy_old <= '0;
        end else begin
            srat <= srat_nxt;
            crat <= crat_nxt;
            if (flush) begin
                out_valid <= '0;
            end else if (accept) begin
                out_valid      <= in_valid;
                out_rs1_phy    <= rs1_p;
                out_rs2_phy    <= rs2_p;
                out_rd_phy_new <= new_p;
                out_rd_phy_old <= old_p;
            end else if (out_ready) begin
                out_valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rename_group.sv
// Scoreboard bench for rename_group: directed groups push expected outputs, a negedge monitor pops and compares.
module tb_rename_group;
    localparam int W  = 2;
    localparam int PW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic [W-1:0]    in_valid = '0;
    logic            in_ready;
    logic [W*5-1:0]  in_rs1_arch = '0, in_rs2_arch = '0, in_rd_arch = '0;
    logic [W-1:0]    in_rd_wen = '0;
    logic [PW:0]     fl_avail = '0;
    logic [W*PW-1:0] fl_phy = '0;
    logic [PW:0]     fl_pop;
    logic [W-1:0]    commit_valid = '0;
    logic [W*5-1:0]  commit_rd_arch = '0;
    logic [W*PW-1:0] commit_rd_phy = '0;
    logic [W-1:0]    out_valid;
    logic            out_ready = 1'b1;
    logic [W*PW-1:0] out_rs1_phy, out_rs2_phy, out_rd_phy_new, out_rd_phy_old;

    rename_group dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_arch(in_rs1_arch), .in_rs2_arch(in_rs2_arch), .in_rd_arch(in_rd_arch),
        .in_rd_wen(in_rd_wen), .fl_avail(fl_avail), .fl_phy(fl_phy), .fl_pop(fl_pop),
        .commit_valid(commit_valid), .commit_rd_arch(commit_rd_arch), .commit_rd_phy(commit_rd_phy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_phy(out_rs1_phy), .out_rs2_phy(out_rs2_phy),
        .out_rd_phy_new(out_rd_phy_new), .out_rd_phy_old(out_rd_phy_old)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]    v;
        logic [W*PW-1:0] rs1, rs2, nw, old;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] v, input logic [5:0] a0, a1, b0, b1, n0, n1, o0, o1);
        exp_t e;
        e.v   = v;
        e.rs1 = {a1, a0};
        e.rs2 = {b1, b0};
        e.nw  = {n1, n0};
        e.old = {o1, o0};
        return e;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [4:0] s1_0, s1_1, s2_0, s2_1, d0, d1,
                         input logic [1:0] wen, input int avail, input logic [5:0] p0, p1);
        in_valid    = v;
        in_rs1_arch = {s1_1, s1_0};
        in_rs2_arch = {s2_1, s2_0};
        in_rd_arch  = {d1, d0};
        in_rd_wen   = wen;
        fl_avail    = 7'(avail);
        fl_phy      = {p1, p0};
    endtask

    // Checks handshake for the currently driven group, records its expected output, advances one cycle.
    task automatic issue(input string name, input logic exp_rdy, input int exp_pop, input exp_t e);
        #1;
        chk({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({name, " fl_pop"}, 32'(fl_pop), 32'(exp_pop));
        if (exp_rdy) q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    always @(negedge clk) begin
        if (rst && (out_valid != '0) && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got valid 0x%0h expected none", out_valid);
            end else begin
                mon_e = q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(mon_e.v));
                chk("out_rs1_phy", 32'(out_rs1_phy), 32'(mon_e.rs1));
                chk("out_rs2_phy", 32'(out_rs2_phy), 32'(mon_e.rs2));
                chk("out_rd_phy_new", 32'(out_rd_phy_new), 32'(mon_e.nw));
                chk("out_rd_phy_old", 32'(out_rd_phy_old), 32'(mon_e.old));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Valid group presented during reset must not be accepted.
        drive(2'b01, 1, 0, 2, 0, 5, 0, 2'b01, 10, 40, 41);
        #3;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst fl_pop", 32'(fl_pop), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_rd_phy_new", 32'(out_rd_phy_new), 32'd0);
        chk("rst out_rd_phy_old", 32'(out_rd_phy_old), 32'd0);
        chk("rst out_rs1_phy", 32'(out_rs1_phy), 32'd0);
        #18;
        chk("rst out_valid held", 32'(out_valid), 32'd0);
        in_valid = '0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single renaming lane: x5 -> 40.
        drive(2'b01, 1, 0, 2, 0, 5, 0, 2'b01, 10, 40, 41);
        issue("t1", 1'b1, 1, mk(2'b01, 1, 0, 2, 0, 40, 0, 5, 0));

        // Intra-group bypass on x3, plus SRAT[5]=40 from t1.
        drive(2'b11, 5, 3, 0, 5, 3, 3, 2'b11, 10, 40, 41);
        issue("t2", 1'b1, 2, mk(2'b11, 40, 40, 0, 40, 40, 41, 3, 40));

        // SRAT[3]=41 (youngest wins); store lane and rd=x0 lane take no register.
        drive(2'b11, 3, 3, 5, 0, 0, 0, 2'b10, 10, 50, 51);
        issue("t3", 1'b1, 0, mk(2'b11, 41, 41, 40, 0, 0, 0, 0, 0));

        // Not enough free registers.
        drive(2'b11, 0, 0, 0, 0, 8, 9, 2'b11, 1, 60, 61);
        issue("t4 short", 1'b0, 0, '0);
        chk("t4 out_valid cleared", 32'(out_valid), 32'd0);
        chk("t4 out_rs1 unchanged", 32'(out_rs1_phy), 32'({6'd41, 6'd41}));

        out_ready = 1'b0;
        drive(2'b11, 0, 0, 0, 0, 8, 9, 2'b11, 2, 60, 61);
        issue("t4b", 1'b1, 2, mk(2'b11, 0, 0, 0, 0, 60, 61, 8, 9));

        // Output stall for three cycles, with a commit x12->30 landing meanwhile.
        drive(2'b11, 8, 10, 0, 0, 10, 0, 2'b01, 10, 62, 63);
        commit_valid   = 2'b01;
        commit_rd_arch = {5'd0, 5'd12};
        commit_rd_phy  = {6'd0, 6'd30};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall fl_pop", 32'(fl_pop), 32'd0);
            chk("stall out_valid", 32'(out_valid), 32'd3);
            chk("stall out_rd_phy_new", 32'(out_rd_phy_new), 32'({6'd61, 6'd60}));
            chk("stall out_rd_phy_old", 32'(out_rd_phy_old), 32'({6'd9, 6'd8}));
            @(posedge clk);
            #1;
            commit_valid = '0;
        end
        out_ready = 1'b1;
        issue("t5", 1'b1, 1, mk(2'b11, 60, 62, 0, 0, 62, 0, 10, 0));

        // SRAT[7]=50 while two same-cycle commits to x9 land (lane1 youngest).
        drive(2'b01, 0, 0, 0, 0, 7, 0, 2'b01, 10, 50, 51);
        commit_valid   = 2'b11;
        commit_rd_arch = {5'd9, 5'd9};
        commit_rd_phy  = {6'd21, 6'd20};
        issue("t6", 1'b1, 1, mk(2'b01, 0, 0, 0, 0, 50, 0, 7, 0));
        commit_valid = '0;

        // Flush with same-cycle commit x7->44 and an ignored x0 commit.
        drive(2'b01, 0, 0, 0, 0, 11, 0, 2'b01, 10, 52, 53);
        flush          = 1'b1;
        commit_valid   = 2'b11;
        commit_rd_arch = {5'd0, 5'd7};
        commit_rd_phy  = {6'd33, 6'd44};
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        chk("flush fl_pop", 32'(fl_pop), 32'd0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        commit_valid = '0;
        in_valid     = '0;
        chk("flush out_valid", 32'(out_valid), 32'd0);

        // Post-flush reads come from the committed map.
        drive(2'b11, 7, 12, 9, 5, 0, 0, 2'b00, 10, 0, 0);
        issue("t7", 1'b1, 0, mk(2'b11, 44, 30, 21, 5, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
